// File: rtl/valu_pkg.sv
// Shared types for the vector ALU issue controller.
// Op codes, register ids, FSM states and tracking-pipe stage layout.
package valu_pkg;

    localparam int LAT_DEFAULT  = 8;
    localparam int NREG_DEFAULT = 64;

    typedef logic [5:0] reg_id_t;

    typedef enum logic [4:0] {
        OP_FADD  = 5'd0,
        OP_FSUB  = 5'd1,
        OP_FMUL  = 5'd2,
        OP_FDIV  = 5'd3,
        OP_FMIN  = 5'd4,
        OP_FMAX  = 5'd5,
        OP_VADD  = 5'd6,
        OP_VSUB  = 5'd7,
        OP_VMULT = 5'd8,
        OP_VMAC  = 5'd9,
        OP_VSMA  = 5'd10,
        OP_VAND  = 5'd11,
        OP_VOR   = 5'd12,
        OP_VXOR  = 5'd13,
        OP_VSLL  = 5'd14,
        OP_VSRL  = 5'd15,
        OP_VSRA  = 5'd16,
        OP_VMAX  = 5'd17,
        OP_VMIN  = 5'd18
    } valu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic    vld;
        logic    wr;
        reg_id_t dst;
    } stage_t;

endpackage

// File: rtl/valu_scoreboard.sv
// Pending-write scoreboard for scalar and vector register ids.
// Reads see registered state only, so a same-cycle clear still stalls.
module valu_scoreboard
    import valu_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    set_i,
    input  reg_id_t set_id_i,
    input  logic    clr_i,
    input  reg_id_t clr_id_i,
    input  reg_id_t rd1_id_i,
    input  reg_id_t rd2_id_i,
    input  reg_id_t dst_id_i,
    output logic    rd1_o,
    output logic    rd2_o,
    output logic    dst_o
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Set applied after clear so a new writer wins over a retiring one
    always_comb begin
        pend_d = pend_q;
        if (clr_i) pend_d[clr_id_i] = 1'b0;
        if (set_i) pend_d[set_id_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign rd1_o = pend_q[rd1_id_i];
    assign rd2_o = pend_q[rd2_id_i];
    assign dst_o = pend_q[dst_id_i];

endmodule

// File: rtl/valu_issue_ctrl.sv
// Vector ALU issue controller: hazard check, LAT-deep tracking pipe,
// writeback backpressure, in-flight counter and activity FSM.
module valu_issue_ctrl
    import valu_pkg::*;
#(
    parameter int LAT  = LAT_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_op,
    input  logic [5:0] req_dst,
    input  logic       req_wr,
    input  logic [5:0] req_src1,
    input  logic [5:0] req_src2,
    input  logic [1:0] req_use,
    output logic       alu_en,
    output logic [4:0] alu_op,
    output logic       alu_issue,
    output logic       wb_valid,
    output logic [5:0] wb_dst,
    input  logic       wb_ready,
    output logic       busy
);

    localparam int CW = $clog2(LAT + 1);

    stage_t [LAT-1:0] pipe_q;
    stage_t [LAT-1:0] pipe_d;
    stage_t           tail;
    logic [CW-1:0]    inflight_q;
    logic [CW-1:0]    inflight_d;
    state_e           state_q;

    logic p1, p2, pd;
    logic hazard, issue, retire, wb_hs;

    valu_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_i    (issue && req_wr),
        .set_id_i (req_dst),
        .clr_i    (wb_hs),
        .clr_id_i (tail.dst),
        .rd1_id_i (req_src1),
        .rd2_id_i (req_src2),
        .dst_id_i (req_dst),
        .rd1_o    (p1),
        .rd2_o    (p2),
        .dst_o    (pd)
    );

    assign tail = pipe_q[LAT-1];

    // Outputs forced to idle values while reset is asserted
    assign alu_en    = !rst_n || !(tail.vld && tail.wr && !wb_ready);
    assign hazard    = rst_n && ((req_use[0] && p1) ||
                                 (req_use[1] && p2) ||
                                 (req_wr && pd));
    assign req_ready = alu_en && !hazard;
    assign issue     = rst_n && req_valid && req_ready;
    assign alu_issue = issue;
    assign alu_op    = issue ? req_op : 5'd0;
    assign wb_valid  = rst_n && tail.vld && tail.wr;
    assign wb_dst    = wb_valid ? tail.dst : 6'd0;
    assign wb_hs     = wb_valid && wb_ready;
    assign retire    = rst_n && tail.vld && alu_en;
    assign busy      = rst_n && (state_q != ST_IDLE);

    always_comb begin
        pipe_d = pipe_q;
        if (alu_en) begin
            for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
            pipe_d[0] = {issue, issue && req_wr,
                         issue ? req_dst : 6'd0};
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q     <= '0;
            inflight_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (issue) state_q <= ST_RUN;
                ST_RUN: begin
                    if (!alu_en)
                        state_q <= ST_HOLD;
                    else if (inflight_d == '0 && !issue)
                        state_q <= ST_IDLE;
                end
                ST_HOLD: if (wb_ready) state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Scoreboard bench for valu_issue_ctrl: directed stimulus pushes
// expected writebacks, a negedge monitor pops and compares them.
module tb_valu_issue_ctrl;
    import valu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_op;
    logic [5:0] req_dst;
    logic       req_wr;
    logic [5:0] req_src1;
    logic [5:0] req_src2;
    logic [1:0] req_use;
    logic       alu_en;
    logic [4:0] alu_op;
    logic       alu_issue;
    logic       wb_valid;
    logic [5:0] wb_dst;
    logic       wb_ready;
    logic       busy;

    typedef struct {
        logic [5:0] dst;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   t0;
    int   iss;

    valu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_dst   (req_dst),
        .req_wr    (req_wr),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_use   (req_use),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_issue (alu_issue),
        .wb_valid  (wb_valid),
        .wb_dst    (wb_dst),
        .wb_ready  (wb_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        req_op    = 5'd0;
        req_dst   = 6'd0;
        req_wr    = 1'b0;
        req_src1  = 6'd0;
        req_src2  = 6'd0;
        req_use   = 2'b00;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 60) begin
            step();
            n++;
        end
        chk(nm, exp_q.size() + int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got dst %0h, none expected",
                         wb_dst);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_dst", wb_dst, mon_e.dst);
                chk("wb_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        rst_n    = 1'b0;
        wb_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_alu_en", alu_en, 1);
        chk("rst_alu_issue", alu_issue, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_dst", wb_dst, 0);
        chk("rst_busy", busy, 0);
        step();
        rst_n = 1'b1;

        // single Vadd, fixed latency
        t0 = cyc;
        req_valid = 1'b1;
        req_op    = OP_VADD;
        req_dst   = 6'h21;
        req_wr    = 1'b1;
        exp_q.push_back('{dst: 6'h21, cyc: t0 + 8});
        @(negedge clk);
        chk("single_issue", alu_issue, 1);
        chk("single_op", alu_op, OP_VADD);
        step();
        idle_in();
        while (cyc < t0 + 8) step();
        @(negedge clk);
        chk("single_busy_c8", busy, 1);
        chk("single_wbv_c8", wb_valid, 1);
        step();
        @(negedge clk);
        chk("single_busy_c9", busy, 0);

        // RAW hazard on 0x22
        step();
        t0 = cyc;
        req_valid = 1'b1;
        req_op    = OP_VADD;
        req_dst   = 6'h22;
        req_wr    = 1'b1;
        exp_q.push_back('{dst: 6'h22, cyc: t0 + 8});
        @(negedge clk);
        chk("raw_first_issue", alu_issue, 1);
        step();
        req_op   = OP_VMULT;
        req_dst  = 6'h23;
        req_src1 = 6'h22;
        req_use  = 2'b01;
        exp_q.push_back('{dst: 6'h23, cyc: t0 + 17});
        iss = -1;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("raw_stall_ready", req_ready, 0);
            if (alu_issue) begin
                iss = cyc - t0;
                break;
            end
            step();
        end
        chk("raw_issue_cycle", iss, 9);
        step();
        idle_in();
        drain("raw_drain");

        // back-to-back with writeback backpressure
        step();
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{dst: 6'h30 + 6'(i),
                              cyc: t0 + (i < 2 ? 8 + i : 11 + i)});
        for (int c = 0; c < 20; c++) begin
            if (c > 0) step();
            req_valid = (c < 8);
            req_op    = OP_VADD;
            req_dst   = 6'h30 + 6'(c);
            req_wr    = (c < 8);
            wb_ready  = !(c >= 10 && c <= 12);
            @(negedge clk);
            if (c < 8) chk("b2b_issue", alu_issue, 1);
            if (c >= 10 && c <= 12) chk("b2b_stall_en", alu_en, 0);
            if (c == 11) chk("b2b_hold_busy", busy, 1);
            if (c == 13) chk("b2b_resume_en", alu_en, 1);
            if (c == 19) chk("b2b_idle", busy, 0);
        end
        step();
        idle_in();
        wb_ready = 1'b1;
        drain("b2b_drain");

        // non-writing op retires silently
        t0 = cyc;
        req_valid = 1'b1;
        req_op    = OP_VSMA;
        req_dst   = 6'h25;
        req_wr    = 1'b0;
        @(negedge clk);
        chk("nowr_issue", alu_issue, 1);
        step();
        idle_in();
        while (cyc < t0 + 9) step();
        @(negedge clk);
        chk("nowr_busy_c9", busy, 0);
        step();
        req_valid = 1'b1;
        req_op    = OP_VMIN;
        req_src1  = 6'h25;
        req_use   = 2'b01;
        @(negedge clk);
        chk("nowr_not_pending", req_ready, 1);
        chk("nowr_reader_issue", alu_issue, 1);
        step();
        idle_in();
        drain("nowr_drain");

        // issue 0x05 while 0x06 retires
        t0 = cyc;
        req_valid = 1'b1;
        req_op    = OP_VADD;
        req_dst   = 6'h06;
        req_wr    = 1'b1;
        exp_q.push_back('{dst: 6'h06, cyc: t0 + 8});
        step();
        idle_in();
        while (cyc < t0 + 8) step();
        req_valid = 1'b1;
        req_op    = OP_VSUB;
        req_dst   = 6'h05;
        req_wr    = 1'b1;
        exp_q.push_back('{dst: 6'h05, cyc: t0 + 16});
        @(negedge clk);
        chk("setclr_issue", alu_issue, 1);
        step();
        idle_in();
        req_src1 = 6'h06;
        req_use  = 2'b01;
        @(negedge clk);
        chk("setclr_06_free", req_ready, 1);
        step();
        req_src1 = 6'h05;
        @(negedge clk);
        chk("setclr_05_pend", req_ready, 0);
        step();
        idle_in();
        drain("setclr_drain");

        // reset with three ops in flight
        t0 = cyc;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            req_valid = 1'b1;
            req_op    = OP_VXOR;
            req_dst   = 6'h10 + 6'(c);
            req_wr    = 1'b1;
        end
        step();
        idle_in();
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        req_src1 = 6'h10;
        req_use  = 2'b01;
        @(negedge clk);
        chk("mrst_req_ready", req_ready, 1);
        chk("mrst_alu_en", alu_en, 1);
        chk("mrst_alu_issue", alu_issue, 0);
        chk("mrst_alu_op", alu_op, 0);
        chk("mrst_wb_valid", wb_valid, 0);
        chk("mrst_busy", busy, 0);
        step();
        idle_in();
        repeat (14) step();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/valu_issue_ctrl.md
VALU_ISSUE_CTRL -- requirements
Module: valu_issue_ctrl

Interface
REQ-001 Parameter LAT, default 8, meaning vector ALU result latency in enabled cycles, legal range 2..15.
REQ-002 Parameter NREG, default 64, meaning scoreboard entries (32 scalar + 32 vector).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  requester presents an operation.
REQ-006 req_ready  output  1  controller accepts the operation this cycle.
REQ-007 req_op  input  5  operation code, valu_pkg op enum (Fadd=0 .. Vmin=18).
REQ-008 req_dst  input  6  destination id: bit5=1 vector file, bits4:0 index.
REQ-009 req_wr  input  1  operation writes req_dst.
REQ-010 req_src1, req_src2  input  6 each  source ids, same encoding as req_dst.
REQ-011 req_use  input  2  bit0: src1 read, bit1: src2 read.
REQ-012 alu_en  output  1  drives vector ALU pipeline enable.
REQ-013 alu_op  output  5  drives vector ALU op; equals req_op on issue, else 0.
REQ-014 alu_issue  output  1  an operation enters the ALU this cycle.
REQ-015 wb_valid  output  1  result at ALU output is to be written back.
REQ-016 wb_dst  output  6  destination id of that result.
REQ-017 wb_ready  input  1  writeback port accepts the result.
REQ-018 busy  output  1  any operation in flight.

Function
REQ-019 Tracking pipe: LAT stages of {vld, wr, dst}; stage 0 loaded on issue, each stage advances only when alu_en=1.
REQ-020 alu_en = NOT(stage[LAT-1].vld AND stage[LAT-1].wr AND NOT wb_ready); when 0 all stages and counters hold.
REQ-021 Hazard = (req_use[0] AND pending[req_src1]) OR (req_use[1] AND pending[req_src2]) OR (req_wr AND pending[req_dst]).
REQ-022 req_ready = alu_en AND NOT hazard; issue = req_valid AND req_ready; no bypass.
REQ-023 Non-issuing enabled cycle inserts a bubble (vld=0) into stage 0.
REQ-024 wb_valid = stage[LAT-1].vld AND stage[LAT-1].wr; wb_dst = stage[LAT-1].dst; ops with wr=0 retire silently.
REQ-025 Result handshake: wb_valid AND wb_ready clears pending[wb_dst]; issue with req_wr sets pending[req_dst].
REQ-026 Same-cycle set and clear of one entry: set wins (cannot arise due to REQ-021, still defined).
REQ-027 A source matching the entry being cleared this cycle still stalls; issue permitted next cycle.
REQ-028 inflight counter, width clog2(LAT+1): +1 on issue, -1 on retire of stage[LAT-1].vld with alu_en=1, unchanged on both/neither; never exceeds LAT.
REQ-029 FSM IDLE/RUN/HOLD: IDLE->RUN on issue; RUN->HOLD when alu_en=0; HOLD->RUN when wb_ready=1; RUN->IDLE when inflight reaches 0 with no issue.
REQ-030 busy = (state != IDLE).
REQ-031 Single issue per cycle, results leave in issue order, exactly LAT enabled cycles after issue.

Reset
REQ-032 When rst_n=0 at a clock edge: all stage vld=0, pending all 0, inflight=0, state=IDLE.
REQ-033 Outputs during/after reset: req_ready=1, alu_en=1, alu_issue=0, alu_op=0, wb_valid=0, wb_dst=0, busy=0.
REQ-034 Reset mid-operation discards all in-flight operations; no wb_valid for them afterwards.

Structure
REQ-035 valu_pkg holds op enum, reg_id_t (6-bit), default LAT, FSM state enum.
REQ-036 Scoreboard is sub-module valu_scoreboard (NREG-bit pending vector, set/clear ports, two read ports + dst check).
REQ-037 Tracking pipe, FSM and counter live in valu_issue_ctrl.

Verification
REQ-038 Single Vadd dst=0x21, wb_ready=1 -> alu_issue at cycle 0, wb_valid with wb_dst=0x21 at cycle 8, busy low at cycle 9.
REQ-039 Vadd dst=0x22 then Vmult src1=0x22 next cycle -> second held req_ready=0 until the cycle after writeback, issues at cycle 9.
REQ-040 8 independent back-to-back ops, wb_ready low cycles 10-12 -> alu_en low those cycles, no result lost or duplicated, order preserved.
REQ-041 Op with req_wr=0 (Vsma) -> no wb_valid, inflight returns to 0, pending unchanged.
REQ-042 Three ops in flight, rst_n low one cycle -> all outputs at reset values next cycle, no later wb_valid.
REQ-043 Issue dst=0x05 while older op dst=0x06 retires -> pending[0x05]=1, pending[0x06]=0 next cycle.
